// File: rtl/tx_burst_ctrl_pkg.sv
// Shared D-PHY TX package for the burst controller slice.
// Holds the controller state encoding, the parameter defaults used by the
// top level and the bench, and helpers that size the shared timer.
package tx_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_WAIT = 3'd1,
    ST_SEND     = 3'd2,
    ST_TRAIL    = 3'd3,
    ST_GAP      = 3'd4
  } txState_e;

  localparam int PREP_TO_DEF   = 64;
  localparam int TRAIL_CYC_DEF = 4;
  localparam int LP_GAP_DEF    = 8;
  localparam int LEN_W         = 16;
  localparam int BYTE_W        = 8;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The timer counts from 0 up to (limit - 1), so log2(limit) bits suffice.
  function automatic int timerWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal);
  endfunction

endpackage

// File: rtl/tx_burst_ctrl_if.sv
// Bundle of the requester-side and lane-side signals of tx_burst_ctrl.
//   master : the burst controller (drives grants, strobes, TX_REQ, HS data)
//   slave  : the environment (requesters and lane FSM)
// Signals:
//   REQ_VALID[1:0], REQ_LEN0/1[15:0], DATA0/1[7:0] : requester inputs
//   DATA_RD[1:0], REQ_GRANT[1:0]                   : requester feedback
//   TX_REQ, TX_HS_ACTIVE                           : lane FSM handshake
//   TX_HS_DATA[7:0], TX_HS_VALID                   : HS serializer feed
//   BUSY, ERR                                      : status
interface tx_burst_ctrl_if;
  import tx_burst_ctrl_pkg::*;

  logic [1:0]        REQ_VALID;
  logic [LEN_W-1:0]  REQ_LEN0;
  logic [LEN_W-1:0]  REQ_LEN1;
  logic [BYTE_W-1:0] DATA0;
  logic [BYTE_W-1:0] DATA1;
  logic [1:0]        DATA_RD;
  logic [1:0]        REQ_GRANT;
  logic              TX_REQ;
  logic              TX_HS_ACTIVE;
  logic [BYTE_W-1:0] TX_HS_DATA;
  logic              TX_HS_VALID;
  logic              BUSY;
  logic              ERR;

  modport master (
    input  REQ_VALID, REQ_LEN0, REQ_LEN1, DATA0, DATA1, TX_HS_ACTIVE,
    output DATA_RD, REQ_GRANT, TX_REQ, TX_HS_DATA, TX_HS_VALID, BUSY, ERR
  );

  modport slave (
    output REQ_VALID, REQ_LEN0, REQ_LEN1, DATA0, DATA1, TX_HS_ACTIVE,
    input  DATA_RD, REQ_GRANT, TX_REQ, TX_HS_DATA, TX_HS_VALID, BUSY, ERR
  );

endinterface

// File: rtl/tx_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i[1:0]   : request vector
//   en_i         : arbitration allowed this cycle (commits the pointer)
//   gnt_o[1:0]   : one-hot grant, combinational, zero when not enabled
//   win_o        : index of the requester that would win this cycle
module tx_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

  logic last_q;
  logic last_d;
  logic winSel;

  // Pick the winner: a lone requester always wins, on a tie the one not
  // granted last wins. The pointer only moves when a grant is committed.
  always_comb begin
    winSel = 1'b0;
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   winSel = 1'b0;
      2'b10:   winSel = 1'b1;
      2'b11:   winSel = ~last_q;
      default: winSel = 1'b0;
    endcase
    if (en_i && (req_i != 2'b00)) begin
      gnt_o  = winSel ? 2'b10 : 2'b01;
      last_d = winSel;
    end
  end

  assign win_o = winSel;

  // Pointer register; after reset requester 1 counts as last granted so
  // requester 0 takes the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tx_burst_ctrl.sv
// D-PHY TX burst controller: arbitrates between two byte requesters, asks
// the lane FSM for HS mode, streams the granted burst to the serializer,
// holds TX_REQ for a trail period and enforces an LP gap between bursts.
// Ports:
//   TX_BYTE_clk : byte clock
//   TX_rst      : asynchronous active-high reset
//   bus         : tx_burst_ctrl_if master modport (requesters, lane, status)
// Parameters:
//   PREP_TO   : REQ_WAIT cycles allowed before giving up on TX_HS_ACTIVE
//   TRAIL_CYC : TRAIL cycles after the last byte
//   LP_GAP    : GAP cycles before arbitration resumes
module tx_burst_ctrl
  import tx_burst_ctrl_pkg::*;
#(
  parameter int PREP_TO   = PREP_TO_DEF,
  parameter int TRAIL_CYC = TRAIL_CYC_DEF,
  parameter int LP_GAP    = LP_GAP_DEF
) (
  input  logic     TX_BYTE_clk,
  input  logic     TX_rst,
  tx_burst_ctrl_if.master bus
);

  localparam int TMR_W = timerWidth(maxOf3(PREP_TO, TRAIL_CYC, LP_GAP));
  localparam logic [TMR_W-1:0] PREP_LAST  = TMR_W'(PREP_TO - 1);
  localparam logic [TMR_W-1:0] TRAIL_LAST = TMR_W'(TRAIL_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(LP_GAP - 1);

  txState_e         state_q,  state_d;
  logic [TMR_W-1:0] tmr_q,    tmr_d;
  logic [LEN_W-1:0] remCnt_q, remCnt_d;
  logic             winner_q, winner_d;
  logic [1:0]       grant_q,  grant_d;
  logic             err_q,    err_d;
  logic             txReq_q,  txReq_d;

  logic             arbEn;
  logic [1:0]       arbGnt;
  logic             arbWin;
  logic [LEN_W-1:0] selLen;
  logic             sendNow;

  // Arbitration is held off for the cycle the grant pulse is visible, so a
  // requester still showing REQ_VALID that cycle is not granted twice.
  assign arbEn  = (state_q == ST_IDLE) && (grant_q == 2'b00);
  assign selLen = arbWin ? bus.REQ_LEN1 : bus.REQ_LEN0;

  tx_rr_arb2 u_arb (
    .clk_i (TX_BYTE_clk),
    .rst_i (TX_rst),
    .req_i (bus.REQ_VALID),
    .en_i  (arbEn),
    .gnt_o (arbGnt),
    .win_o (arbWin)
  );

  // A byte moves only while in SEND with the lane still in HS; the cycle in
  // which the lane drops out is the abort cycle and transfers nothing.
  assign sendNow         = (state_q == ST_SEND) && bus.TX_HS_ACTIVE;
  assign bus.TX_HS_VALID = sendNow;
  assign bus.TX_HS_DATA  = sendNow ? (winner_q ? bus.DATA1 : bus.DATA0) : '0;
  assign bus.DATA_RD     = sendNow ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.TX_REQ      = txReq_q;
  assign bus.REQ_GRANT   = grant_q;
  assign bus.ERR         = err_q;

  // Next-state logic. The single timer is reused by REQ_WAIT, TRAIL and GAP
  // and is cleared on every entry into one of them. A zero-length grant
  // still pulses REQ_GRANT and moves the pointer but never leaves IDLE.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    remCnt_d = remCnt_q;
    winner_d = winner_q;
    grant_d  = 2'b00;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arbGnt != 2'b00) begin
          grant_d  = arbGnt;
          winner_d = arbWin;
          remCnt_d = selLen;
          tmr_d    = '0;
          if (selLen != '0) begin
            state_d = ST_REQ_WAIT;
          end
        end
      end
      ST_REQ_WAIT: begin
        if (bus.TX_HS_ACTIVE) begin
          state_d = ST_SEND;
          tmr_d   = '0;
        end else if (tmr_q == PREP_LAST) begin
          err_d   = 1'b1;
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SEND: begin
        if (!bus.TX_HS_ACTIVE) begin
          err_d    = 1'b1;
          state_d  = ST_GAP;
          tmr_d    = '0;
          remCnt_d = '0;
        end else begin
          remCnt_d = remCnt_q - LEN_W'(1);
          if (remCnt_q == LEN_W'(1)) begin
            state_d = ST_TRAIL;
            tmr_d   = '0;
          end
        end
      end
      ST_TRAIL: begin
        if (tmr_q == TRAIL_LAST) begin
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // TX_REQ is decoded from the next state so the registered copy lines up
  // exactly with REQ_WAIT, SEND and TRAIL.
  assign txReq_d = (state_d == ST_REQ_WAIT) || (state_d == ST_SEND) ||
                   (state_d == ST_TRAIL);

  // State and datapath registers; reset drops TX_REQ at once and discards
  // any burst in flight without an error pulse.
  always_ff @(posedge TX_BYTE_clk or posedge TX_rst) begin
    if (TX_rst) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      remCnt_q <= '0;
      winner_q <= 1'b0;
      grant_q  <= 2'b00;
      err_q    <= 1'b0;
      txReq_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      remCnt_q <= remCnt_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      txReq_q  <= txReq_d;
    end
  end

endmodule
